// File: rtl/walk_request_bank_if.sv
// Bus between the walk-request bank and its users.
//
// Signals:
//   WR_Sync    [NUM_CH]  synchronized button request per crossing (level or pulse)
//   WR_Reset   [NUM_CH]  explicit clear per crossing
//   Serve                phase FSM served channel Sel this cycle
//   WR         [NUM_CH]  pending request flags (registered)
//   Urgent     [NUM_CH]  pending and waited >= MAX_WAIT
//   Any_WR               OR of WR
//   Sel        [SEL_W]   channel chosen for next service
//   Sel_Urgent           chosen channel is urgent
//
// Handshake: there is no valid/ready pair on this bus. Serve is a one-cycle
// strobe that the bank always accepts on the rising edge it is sampled at;
// it only has an effect when Any_WR is high in that same cycle, and it always
// refers to the Sel value visible in that cycle. WR_Sync/WR_Reset are
// per-channel levels sampled every edge.
//
// Modports: master drives requests (button sync + phase FSM side),
//           slave is the bank itself.
interface walk_request_bank_if #(
  parameter int NUM_CH = 4
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] WR_Sync;
  logic [NUM_CH-1:0] WR_Reset;
  logic              Serve;
  logic [NUM_CH-1:0] WR;
  logic [NUM_CH-1:0] Urgent;
  logic              Any_WR;
  logic [SEL_W-1:0]  Sel;
  logic              Sel_Urgent;

  modport master (
    output WR_Sync, WR_Reset, Serve,
    input  WR, Urgent, Any_WR, Sel, Sel_Urgent
  );

  modport slave (
    input  WR_Sync, WR_Reset, Serve,
    output WR, Urgent, Any_WR, Sel, Sel_Urgent
  );
endinterface

// File: rtl/walk_request_bank.sv
// Multi-channel pedestrian walk-request register.
//
// Per crossing it latches a synchronized button request until the phase FSM
// serves it or it is explicitly cleared, tracks how long it has waited, flags
// over-age requests as urgent, and picks the next crossing to serve
// (round-robin, urgent first).
//
// Ports:
//   clk    in  system clock, all state on the rising edge
//   Rst_n  in  synchronous active-low reset
//   bus    walk_request_bank_if.slave (requests in, status/selection out)
//
// All outputs are decoded from registers only; nothing on the bus inputs
// reaches an output combinationally.
module walk_request_bank #(
  parameter int NUM_CH   = 4,
  parameter int AGE_W    = 8,
  parameter int MAX_WAIT = 200,
  parameter int LOCKOUT  = 16
) (
  input  logic                  clk,
  input  logic                  Rst_n,
  walk_request_bank_if.slave    bus
);
  localparam int SEL_W  = $clog2(NUM_CH);
  localparam int LOCK_W = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

  logic [NUM_CH-1:0] wr_q, wr_d;
  logic [AGE_W-1:0]  age_q  [NUM_CH];
  logic [AGE_W-1:0]  age_d  [NUM_CH];
  logic [LOCK_W-1:0] lock_q [NUM_CH];
  logic [LOCK_W-1:0] lock_d [NUM_CH];
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic [NUM_CH-1:0] urgent_c;
  logic              any_wr_c;
  logic [SEL_W-1:0]  sel_c;
  logic              sel_urg_c;
  logic              serve_hit;

  // First set bit of vec in scan order ptr+1, ptr+2, ... (mod NUM_CH).
  // Returns 0 when vec is empty.
  function automatic logic [SEL_W-1:0] first_in_scan(input logic [NUM_CH-1:0] vec,
                                                     input logic [SEL_W-1:0]  ptr);
    logic [SEL_W-1:0] res;
    logic             found;
    int               idx;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && vec[idx]) begin
        res   = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Status and selection, decoded from registers.
  always_comb begin
    any_wr_c  = |wr_q;
    urgent_c  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      urgent_c[i] = wr_q[i] && (age_q[i] >= AGE_W'(MAX_WAIT));
    end
    sel_urg_c = |urgent_c;
    sel_c     = sel_urg_c ? first_in_scan(urgent_c, ptr_q) : first_in_scan(wr_q, ptr_q);
  end

  assign bus.WR         = wr_q;
  assign bus.Urgent     = urgent_c;
  assign bus.Any_WR     = any_wr_c;
  assign bus.Sel        = sel_c;
  assign bus.Sel_Urgent = sel_urg_c;

  // Next state per channel.
  always_comb begin
    logic clr;
    logic set_ok;
    serve_hit = bus.Serve && any_wr_c;
    ptr_d     = serve_hit ? sel_c : ptr_q;
    wr_d      = wr_q;
    clr       = 1'b0;
    set_ok    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      age_d[i]  = age_q[i];
      lock_d[i] = lock_q[i];
      // WR_Reset and a Serve hit on the same channel merge into one clear.
      clr = bus.WR_Reset[i] || (serve_hit && (sel_c == SEL_W'(i)));
      // The counter's last nonzero cycle already admits a set, so a held
      // request lands exactly LOCKOUT edges after the clearing edge.
      set_ok = bus.WR_Sync[i] && (lock_q[i] <= LOCK_W'(1));
      if (clr) begin
        wr_d[i]   = 1'b0;
        age_d[i]  = '0;
        lock_d[i] = LOCK_W'(LOCKOUT);
      end else begin
        wr_d[i] = wr_q[i] || set_ok;
        // Age is 0 in the first pending cycle and saturates at all-ones.
        if (!wr_q[i]) begin
          age_d[i] = '0;
        end else if (age_q[i] != '1) begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
        if (lock_q[i] != '0) begin
          lock_d[i] = lock_q[i] - LOCK_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      wr_q  <= '0;
      ptr_q <= SEL_W'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) begin
        age_q[i]  <= '0;
        lock_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      ptr_q <= ptr_d;
      for (int i = 0; i < NUM_CH; i++) begin
        age_q[i]  <= age_d[i];
        lock_q[i] <= lock_d[i];
      end
    end
  end
endmodule
